// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_pkg
//  Description : Shared types and constants for the pixel sequencer: the
//                sequencer state encoding, pixel code width, ramp length and
//                a helper that sizes counters to their maximum count.
//  Revision    : 1.0 - initial release
// ============================================================================
package pixel_pkg;

  localparam int PIX_W    = 8;
  localparam int RAMP_LEN = 256;
  localparam int RAMP_W   = $clog2(RAMP_LEN);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_ROWSEL  = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_SEND    = 3'd6
  } state_e;

  // Bits needed to hold every value 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    cnt_width = (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_seq_ctrl_ramp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ramp_gen
//  Description : Ramp DAC code counter. Steps once per enabled cycle from 0
//                and saturates at RAMP_LEN-1, where done is raised.
//  Ports       : clk, reset    - clock / synchronous active-high reset
//                enable_i      - advance the code by one this cycle
//                clear_i       - return the code to 0 (wins over enable_i)
//                code_o        - current ramp code
//                done_o        - code has reached its final value
//  Revision    : 1.0 - initial release
// ============================================================================
module ramp_gen
  import pixel_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              clear_i,
  output logic [RAMP_W-1:0] code_o,
  output logic              done_o
);

  logic [RAMP_W-1:0] code_q;
  logic [RAMP_W-1:0] code_d;

  assign done_o = (code_q == RAMP_W'(RAMP_LEN - 1));
  assign code_o = code_q;

  // Holding at the final code keeps the ramp from wrapping if enable lingers.
  always_comb begin
    code_d = code_q;
    if (clear_i) begin
      code_d = '0;
    end else if (enable_i && !done_o) begin
      code_d = code_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q <= '0;
    end else begin
      code_q <= code_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_seq_ctrl
//  Description : Frame sequencer for a ROWS x COLS pixel array. A trigger in
//                IDLE runs erase, expose and ramp-convert phases, then reads
//                the array row by row and streams each row over AXI-Stream.
//  Ports       : clk, reset          - clock / synchronous active-high reset
//                trigger, cfg_expose - frame request and exposure length
//                erase, expose       - pixel phase strobes
//                convert, ramp_code  - ramp conversion enable and DAC code
//                read_sel, row_data  - one-hot row select and its pixel codes
//                m_t*                - AXI-Stream master, one pixel per beat
//                busy, frame_done    - frame in progress / end-of-frame pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_seq_ctrl
  import pixel_pkg::*;
#(
  parameter int ROWS      = 2,
  parameter int COLS      = 2,
  parameter int ERASE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [15:0]           cfg_expose,
  output logic                  erase,
  output logic                  expose,
  output logic                  convert,
  output logic [PIX_W-1:0]      ramp_code,
  output logic [ROWS-1:0]       read_sel,
  input  logic [COLS*PIX_W-1:0] row_data,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [PIX_W-1:0]      m_tdata,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int ERASE_W = cnt_width(ERASE_CYC - 1);
  // One phase counter serves erase and expose; expose needs up to 65534.
  localparam int PH_W    = (ERASE_W > 16) ? ERASE_W : 16;
  localparam int ROW_W   = cnt_width(ROWS - 1);
  localparam int COL_W   = cnt_width(COLS - 1);

  localparam logic [PH_W-1:0]  ERASE_LAST = PH_W'(ERASE_CYC - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);

  state_e                 state_q, state_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [15:0]            exp_q, exp_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [COLS*PIX_W-1:0]  buf_q, buf_d;
  logic                   done_q, done_d;

  logic                   w_ramp_en;
  logic                   w_ramp_clr;
  logic [RAMP_W-1:0]      w_ramp_code;
  logic                   w_ramp_done;
  logic [PIX_W-1:0]       w_pix;
  logic [ROWS-1:0]        w_row_onehot;

  // The ramp sits at 0 in every other state so each CONVERT starts fresh.
  assign w_ramp_clr   = (state_q != ST_CONVERT);
  assign w_row_onehot = ROWS'(1) << row_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = done_q;

  ramp_gen u_ramp_gen (
    .clk      (clk),
    .reset    (reset),
    .enable_i (w_ramp_en),
    .clear_i  (w_ramp_clr),
    .code_o   (w_ramp_code),
    .done_o   (w_ramp_done)
  );

  // Column mux from the captured row buffer.
  always_comb begin
    w_pix = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_q == COL_W'(c)) begin
        w_pix = buf_q[c*PIX_W +: PIX_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    exp_d     = exp_q;
    row_d     = row_q;
    col_d     = col_q;
    buf_d     = buf_q;
    done_d    = 1'b0;
    erase     = 1'b0;
    expose    = 1'b0;
    convert   = 1'b0;
    ramp_code = '0;
    read_sel  = '0;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    m_tlast   = 1'b0;
    w_ramp_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ph_d  = '0;
        row_d = '0;
        col_d = '0;
        if (trigger) begin
          // A zero exposure still gets one expose cycle.
          exp_d   = (cfg_expose == 16'd0) ? 16'd1 : cfg_expose;
          state_d = ST_ERASE;
        end
      end

      ST_ERASE: begin
        erase = 1'b1;
        if (ph_q == ERASE_LAST) begin
          ph_d    = '0;
          state_d = ST_EXPOSE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      ST_EXPOSE: begin
        expose = 1'b1;
        if (ph_q == PH_W'(exp_q - 16'd1)) begin
          ph_d    = '0;
          state_d = ST_CONVERT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      ST_CONVERT: begin
        convert   = 1'b1;
        ramp_code = w_ramp_code;
        w_ramp_en = 1'b1;
        if (w_ramp_done) begin
          state_d = ST_ROWSEL;
        end
      end

      ST_ROWSEL: begin
        read_sel = w_row_onehot;
        state_d  = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        read_sel = w_row_onehot;
        buf_d    = row_data;
        col_d    = '0;
        state_d  = ST_SEND;
      end

      ST_SEND: begin
        m_tvalid = 1'b1;
        m_tdata  = w_pix;
        m_tlast  = (row_q == ROW_LAST) && (col_q == COL_LAST);
        if (m_tready) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = ST_ROWSEL;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      exp_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      exp_q   <= exp_d;
      row_q   <= row_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_seq_ctrl
//  Description : Self-checking bench for pixel_seq_ctrl. Instance A is the
//                default 2x2 array, instance B a 3x4 array. Expected beats
//                are queued when a frame is started and popped on handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_seq_ctrl;

  localparam int AR = 2;
  localparam int AC = 2;
  localparam int AE = 4;
  localparam int BR = 3;
  localparam int BC = 4;
  localparam int BE = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_a, trigger_a, tready_a;
  logic [15:0]   cfg_a;
  logic          erase_a, expose_a, convert_a, tvalid_a, tlast_a, busy_a, done_a;
  logic [7:0]    ramp_a, tdata_a, seed_a;
  logic [AR-1:0] sel_a;
  logic [AC*8-1:0] row_a;

  logic          reset_b, trigger_b, tready_b;
  logic [15:0]   cfg_b;
  logic          erase_b, expose_b, convert_b, tvalid_b, tlast_b, busy_b, done_b;
  logic [7:0]    ramp_b, tdata_b, seed_b;
  logic [BR-1:0] sel_b;
  logic [BC*8-1:0] row_b;

  beat_t q_a[$];
  beat_t q_b[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  pixel_seq_ctrl #(.ROWS(AR), .COLS(AC), .ERASE_CYC(AE)) dut_a (
    .clk(clk), .reset(reset_a), .trigger(trigger_a), .cfg_expose(cfg_a),
    .erase(erase_a), .expose(expose_a), .convert(convert_a), .ramp_code(ramp_a),
    .read_sel(sel_a), .row_data(row_a), .m_tvalid(tvalid_a), .m_tready(tready_a),
    .m_tdata(tdata_a), .m_tlast(tlast_a), .busy(busy_a), .frame_done(done_a)
  );

  pixel_seq_ctrl #(.ROWS(BR), .COLS(BC), .ERASE_CYC(BE)) dut_b (
    .clk(clk), .reset(reset_b), .trigger(trigger_b), .cfg_expose(cfg_b),
    .erase(erase_b), .expose(expose_b), .convert(convert_b), .ramp_code(ramp_b),
    .read_sel(sel_b), .row_data(row_b), .m_tvalid(tvalid_b), .m_tready(tready_b),
    .m_tdata(tdata_b), .m_tlast(tlast_b), .busy(busy_b), .frame_done(done_b)
  );

  function automatic logic [7:0] pix(input logic [7:0] seed, input int r, input int c);
    return seed + 8'(r * 16 + c);
  endfunction

  // Pixel array model: the selected row presents its codes, otherwise junk.
  always_comb begin
    row_a = 16'hDEAD;
    for (int r = 0; r < AR; r++)
      if (sel_a[r])
        for (int c = 0; c < AC; c++) row_a[c*8 +: 8] = pix(seed_a, r, c);
  end

  always_comb begin
    row_b = 32'hDEADBEEF;
    for (int r = 0; r < BR; r++)
      if (sel_b[r])
        for (int c = 0; c < BC; c++) row_b[c*8 +: 8] = pix(seed_b, r, c);
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs_a(input string tag);
    chk_val(tag, 32'({erase_a, expose_a, convert_a, ramp_a, sel_a, tvalid_a,
                      tlast_a, tdata_a, busy_a, done_a}), 32'd0);
  endtask

  task automatic run_frame_a(input logic [15:0] exp_cfg, input logic [7:0] seed,
                             input bit stall, input bit hold);
    int         cyc = 0, n_er = 0, n_ex = 0, n_cv = 0, ramp_err = 0, proto_err = 0;
    int         sel_idx = 0, n_beat = 0, k = 0;
    logic [7:0] ramp_exp = 8'd0;
    logic [AR-1:0] prev_sel = '0;
    logic [9:0] held = '0;
    logic [3:0] pat = 4'b1001;
    bit         stalled = 1'b0, got_done = 1'b0;
    beat_t      b;
    seed_a = seed;
    for (int r = 0; r < AR; r++)
      for (int c = 0; c < AC; c++)
        q_a.push_back('{d: pix(seed, r, c), l: (r == AR-1 && c == AC-1)});
    cfg_a     = exp_cfg;
    trigger_a = 1'b1;
    tready_a  = 1'b1;
    while (!got_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk_val("erase_start", 32'(erase_a), 32'd1);
        if (!hold) trigger_a = 1'b0;
        cfg_a = exp_cfg + 16'd7;
      end
      if (stall) begin
        tready_a = pat[3 - (k % 4)];
        k++;
      end
      if (erase_a)  n_er++;
      if (expose_a) n_ex++;
      if (convert_a) begin
        n_cv++;
        if (ramp_a !== ramp_exp) ramp_err++;
        ramp_exp++;
      end else if (ramp_a !== 8'd0) ramp_err++;
      if (busy_a !== (erase_a | expose_a | convert_a | (|sel_a) | tvalid_a)) proto_err++;
      if (tlast_a && !tvalid_a) proto_err++;
      if (sel_a !== '0 && sel_a !== prev_sel) begin
        chk_val("read_sel_a", 32'(sel_a), 32'(1 << sel_idx));
        sel_idx++;
      end
      prev_sel = sel_a;
      if (stalled) chk_val("stall_hold", 32'({tvalid_a, tlast_a, tdata_a}), 32'(held));
      if (tvalid_a && tready_a) begin
        chk_val("beat_avail_a", 32'(q_a.size() > 0), 32'd1);
        if (q_a.size() > 0) begin
          b = q_a.pop_front();
          chk_val("tdata_a", 32'(tdata_a), 32'(b.d));
          chk_val("tlast_a", 32'(tlast_a), 32'(b.l));
        end
        n_beat++;
      end
      stalled = tvalid_a && !tready_a;
      held    = {tvalid_a, tlast_a, tdata_a};
      if (done_a) got_done = 1'b1;
    end
    chk_val("frame_done_a", 32'(got_done), 32'd1);
    chk_val("erase_cyc", n_er, AE);
    chk_val("expose_cyc", n_ex, (exp_cfg == 16'd0) ? 32'd1 : 32'(exp_cfg));
    chk_val("convert_cyc", n_cv, 256);
    chk_val("ramp_errs", ramp_err, 0);
    chk_val("proto_errs", proto_err, 0);
    chk_val("rows_a", sel_idx, AR);
    chk_val("beats_a", n_beat, AR * AC);
    chk_val("q_empty_a", q_a.size(), 0);
    q_a.delete();
    tready_a = 1'b1;
    @(negedge clk);
    chk_val("done_pulse_a", 32'(done_a), 32'd0);
    if (hold) begin
      chk_val("retrigger", 32'(erase_a), 32'd1);
      trigger_a = 1'b0;
      reset_a   = 1'b1;
      @(negedge clk);
      chk_outs_a("rst_after_retrig");
      reset_a = 1'b0;
    end else begin
      chk_val("idle_busy_a", 32'(busy_a), 32'd0);
    end
  endtask

  task automatic abort_a(input bit in_send);
    int cyc = 0, dn_err = 0;
    bit hit = 1'b0;
    seed_a    = 8'h33;
    cfg_a     = 16'd5;
    trigger_a = 1'b1;
    tready_a  = !in_send;
    while (!hit && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) trigger_a = 1'b0;
      if (in_send ? tvalid_a : (convert_a && ramp_a == 8'd100)) hit = 1'b1;
    end
    chk_val(in_send ? "reach_send" : "reach_convert", 32'(hit), 32'd1);
    reset_a = 1'b1;
    @(negedge clk);
    chk_outs_a(in_send ? "rst_mid_send" : "rst_mid_convert");
    reset_a  = 1'b0;
    tready_a = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done_a || busy_a) dn_err++;
    end
    chk_val("no_done_after_abort", dn_err, 0);
  endtask

  task automatic run_frame_b();
    int         cyc = 0, n_er = 0, n_ex = 0, sel_idx = 0, n_beat = 0;
    bit         got_done = 1'b0;
    logic [BR-1:0] prev_sel = '0;
    beat_t      b;
    seed_b = 8'h90;
    for (int r = 0; r < BR; r++)
      for (int c = 0; c < BC; c++)
        q_b.push_back('{d: pix(seed_b, r, c), l: (r == BR-1 && c == BC-1)});
    cfg_b     = 16'd3;
    trigger_b = 1'b1;
    while (!got_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) trigger_b = 1'b0;
      if (erase_b)  n_er++;
      if (expose_b) n_ex++;
      if (sel_b !== '0 && sel_b !== prev_sel) begin
        chk_val("read_sel_b", 32'(sel_b), 32'(1 << sel_idx));
        sel_idx++;
      end
      prev_sel = sel_b;
      if (tvalid_b && tready_b) begin
        chk_val("beat_avail_b", 32'(q_b.size() > 0), 32'd1);
        if (q_b.size() > 0) begin
          b = q_b.pop_front();
          chk_val("tdata_b", 32'(tdata_b), 32'(b.d));
          chk_val("tlast_b", 32'(tlast_b), 32'(b.l));
        end
        n_beat++;
      end
      if (done_b) got_done = 1'b1;
    end
    chk_val("frame_done_b", 32'(got_done), 32'd1);
    chk_val("erase_cyc_b", n_er, BE);
    chk_val("expose_cyc_b", n_ex, 3);
    chk_val("rows_b", sel_idx, BR);
    chk_val("beats_b", n_beat, BR * BC);
    chk_val("q_empty_b", q_b.size(), 0);
    q_b.delete();
  endtask

  initial begin
    reset_a = 1'b1; trigger_a = 1'b0; cfg_a = 16'd0; tready_a = 1'b1; seed_a = 8'h00;
    reset_b = 1'b1; trigger_b = 1'b0; cfg_b = 16'd0; tready_b = 1'b1; seed_b = 8'h00;
    repeat (3) @(negedge clk);
    chk_outs_a("reset_a");
    chk_val("reset_b", 32'({erase_b, expose_b, convert_b, ramp_b, sel_b, tvalid_b,
                            tlast_b, tdata_b, busy_b, done_b}), 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    run_frame_a(16'd10, 8'h10, 1'b0, 1'b0);
    run_frame_a(16'd0,  8'h40, 1'b0, 1'b0);
    run_frame_a(16'd3,  8'h80, 1'b1, 1'b0);
    run_frame_a(16'd6,  8'hC0, 1'b0, 1'b1);
    abort_a(1'b0);
    run_frame_a(16'd2,  8'h21, 1'b0, 1'b0);
    abort_a(1'b1);
    run_frame_a(16'd1,  8'h52, 1'b1, 1'b0);
    run_frame_b();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_seq_ctrl.md
PIXEL_SEQ_CTRL -- requirements
Module: pixel_seq_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 2, number of pixel-array rows.
REQ-002 SHALL have parameter COLS, default 2, number of pixel-array columns.
REQ-003 SHALL have parameter ERASE_CYC, default 4, erase phase length in clk cycles.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port trigger  input  1  start-of-frame request, level-sampled.
REQ-007 SHALL have port cfg_expose  input  16  exposure length in cycles, latched at frame start.
REQ-008 SHALL have port erase  output  1  pixel erase strobe.
REQ-009 SHALL have port expose  output  1  pixel expose enable.
REQ-010 SHALL have port convert  output  1  ramp-conversion enable.
REQ-011 SHALL have port ramp_code  output  8  ramp DAC code during convert.
REQ-012 SHALL have port read_sel  output  ROWS  one-hot row-read select.
REQ-013 SHALL have port row_data  input  COLS*8  pixel codes of selected row, column 0 in bits [7:0].
REQ-014 SHALL have ports m_tvalid output 1, m_tready input 1, m_tdata output 8, m_tlast output 1: AXI-Stream master.
REQ-015 SHALL have ports busy output 1 (frame in progress) and frame_done output 1 (one-cycle pulse).

Function
REQ-016 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, ROWSEL, CAPTURE, SEND.
REQ-017 IDLE: trigger=1 SHALL move to ERASE next cycle and latch cfg_expose; trigger outside IDLE SHALL be ignored.
REQ-018 ERASE SHALL hold erase=1 for exactly ERASE_CYC cycles, then go to EXPOSE.
REQ-019 EXPOSE SHALL hold expose=1 for exactly max(latched cfg_expose,1) cycles, then go to CONVERT.
REQ-020 CONVERT SHALL hold convert=1 for exactly 256 cycles with ramp_code stepping 0,1,...,255, one step per cycle; ramp_code SHALL be 0 outside CONVERT.
REQ-021 ROWSEL SHALL drive read_sel one-hot for row r (r=0 first) for one settle cycle; CAPTURE SHALL keep read_sel and register row_data into a COLS x 8 row buffer.
REQ-022 read_sel SHALL be all-zero in every state other than ROWSEL and CAPTURE.
REQ-023 SEND SHALL stream buffered pixels column 0 to COLS-1, one beat per m_tvalid&&m_tready cycle.
REQ-024 m_tvalid SHALL be 1 only in SEND; m_tdata and m_tlast SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-025 m_tlast SHALL be 1 only on the final beat (row ROWS-1, column COLS-1), giving ROWS*COLS beats per frame.
REQ-026 After the last beat of a non-final row SHALL return to ROWSEL with r+1; after the final beat SHALL return to IDLE and pulse frame_done for one cycle.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Phase counters SHALL be sized to their maximum count without wrap; ramp_code SHALL NOT wrap past 255 within a frame.
REQ-029 m_tready deassertion in any state other than SEND SHALL have no effect.

Reset
REQ-030 reset=1 at any cycle SHALL force IDLE on the next edge, aborting any frame with no frame_done.
REQ-031 Reset values: erase, expose, convert, m_tvalid, m_tlast, busy, frame_done = 0; ramp_code, m_tdata = 0; read_sel all-zero; row buffer and counters cleared.

Structure
REQ-032 The state enum, pixel width 8, and ramp length 256 SHALL be defined in shared package pixel_pkg.
REQ-033 The ramp counter SHALL be a sub-module ramp_gen (enable, clear, 8-bit code, done at 255); all else SHALL be in one module.

Verification
REQ-034 reset, trigger one cycle, cfg_expose=10, m_tready=1 -> erase 4 cycles, expose 10, convert 256 with ramp 0..255, 4 beats in order r0c0,r0c1,r1c0,r1c1, m_tlast on beat 4, one frame_done.
REQ-035 cfg_expose=0 -> expose high exactly 1 cycle.
REQ-036 m_tready toggling 1,0,0,1 during SEND -> no beat lost or duplicated, m_tdata stable while stalled.
REQ-037 trigger held high through a whole frame -> second frame starts only after return to IDLE; cfg_expose change mid-frame has no effect.
REQ-038 reset asserted mid-CONVERT and mid-SEND -> all outputs at reset values next cycle, no frame_done, next trigger yields a full correct frame.
REQ-039 ROWS=3, COLS=4 -> 12 beats, read_sel 001,010,100 in sequence, m_tlast only on beat 12.
